// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//  Shared definitions for the UART receive/transmit blocks.
//  Contents: byte width and the frame assembler state encoding.
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int unsigned UART_BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

endpackage

// File: rtl/uart_idle_timer.sv
// ---------------------------------------------------------------------------
// uart_idle_timer
//  Counts enabled cycles since the last clear.
//  'expired' flags the TIMEOUT_CYCLES-th consecutive idle cycle.
//  TIMEOUT_CYCLES = 0 disables the timer.
// Ports:
//  CLK      in   system clock
//  RST      in   asynchronous active-high reset
//  clear    in   restart the count (activity seen this cycle)
//  enable   in   count this cycle; held at 0 while low
//  expired  out  this idle cycle is the last one allowed
// ---------------------------------------------------------------------------
module uart_idle_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic CLK,
    input  logic RST,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned TMR_W    = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned TMR_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam bit          TMR_ON   = (TIMEOUT_CYCLES != 0);

    logic [TMR_W-1:0] r_tmr;

    // Saturating idle counter; the value k means k idle cycles have elapsed.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_tmr <= '0;
        end else if (clear || !enable) begin
            r_tmr <= '0;
        end else if (r_tmr != TMR_W'(TMR_LAST)) begin
            r_tmr <= r_tmr + TMR_W'(1);
        end
    end

    assign expired = TMR_ON && enable && !clear && (r_tmr == TMR_W'(TMR_LAST));

endmodule

// File: rtl/uart_frame_assembler.sv
// ---------------------------------------------------------------------------
// uart_frame_assembler
//  Collects received UART bytes into one NUM_BYTES-wide frame word and
//  offers it on a valid/ready handshake. Partial frames are discarded
//  after an inter-byte idle timeout.
// Ports:
//  CLK, RST      clock, asynchronous active-high reset
//  BYTE_VALID    one-cycle strobe, BYTE_DATA valid
//  BYTE_DATA     received byte
//  FRAME_DATA    assembled frame, stable while FRAME_VALID
//  FRAME_VALID   frame available
//  FRAME_READY   consumer accepts frame (transfer = VALID & READY)
//  BYTE_COUNT    bytes held in the current partial frame
//  OVERFLOW      pulse: byte dropped while a frame was held
//  TIMEOUT_ERR   pulse: partial frame discarded on timeout
// ---------------------------------------------------------------------------
module uart_frame_assembler
    import uart_pkg::*;
#(
    parameter int unsigned NUM_BYTES      = 8,
    parameter bit          LSB_FIRST      = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    localparam int unsigned CNT_W         = $clog2(NUM_BYTES + 1),
    localparam int unsigned FRAME_W       = UART_BYTE_W * NUM_BYTES
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   BYTE_VALID,
    input  logic [UART_BYTE_W-1:0] BYTE_DATA,
    output logic [FRAME_W-1:0]     FRAME_DATA,
    output logic                   FRAME_VALID,
    input  logic                   FRAME_READY,
    output logic [CNT_W-1:0]       BYTE_COUNT,
    output logic                   OVERFLOW,
    output logic                   TIMEOUT_ERR
);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_W-1:0]     r_count,   w_count_nxt;
    logic [FRAME_W-1:0]   r_asm,     w_asm_nxt;
    logic [FRAME_W-1:0]   r_frame,   w_frame_nxt;
    logic                 r_fvalid,  w_fvalid_nxt;
    logic                 r_ovf,     w_ovf_nxt;
    logic                 r_tout,    w_tout_nxt;

    logic                 w_store;
    logic [CNT_W-1:0]     w_idx;
    logic [CNT_W-1:0]     w_lane;
    logic [FRAME_W-1:0]   w_base;
    logic [FRAME_W-1:0]   w_asm_wr;
    logic                 w_tmr_clear;
    logic                 w_tmr_en;
    logic                 w_expired;

    // Idle timer only runs between bytes of a partial frame.
    assign w_tmr_en    = (r_state == ST_COLLECT);
    assign w_tmr_clear = BYTE_VALID || (r_state != ST_COLLECT);

    uart_idle_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_idle_timer (
        .CLK     (CLK),
        .RST     (RST),
        .clear   (w_tmr_clear),
        .enable  (w_tmr_en),
        .expired (w_expired)
    );

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, byte store decode and output next values.
    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_asm_nxt    = r_asm;
        w_frame_nxt  = r_frame;
        w_fvalid_nxt = r_fvalid;
        w_ovf_nxt    = 1'b0;
        w_tout_nxt   = 1'b0;
        w_store      = 1'b0;
        w_idx        = '0;
        w_base       = '0;
        w_asm_wr     = '0;
        w_lane       = '0;

        case (r_state)
            ST_IDLE: begin
                if (BYTE_VALID) begin
                    w_store = 1'b1;
                end
            end
            ST_COLLECT: begin
                if (BYTE_VALID) begin
                    w_store = 1'b1;
                    w_idx   = r_count;
                    w_base  = r_asm;
                end else if (w_expired) begin
                    w_state_nxt = ST_IDLE;
                    w_count_nxt = '0;
                    w_asm_nxt   = '0;
                    w_tout_nxt  = 1'b1;
                end
            end
            ST_HOLD: begin
                if (FRAME_READY) begin
                    w_fvalid_nxt = 1'b0;
                    w_state_nxt  = ST_IDLE;
                    // A byte arriving in the transfer cycle starts the next frame.
                    w_store      = BYTE_VALID;
                end else if (BYTE_VALID) begin
                    w_ovf_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Byte index k maps to lane k, or to the mirrored lane for MSB-first frames.
        w_lane   = LSB_FIRST ? w_idx : (CNT_W'(NUM_BYTES - 1) - w_idx);
        w_asm_wr = w_base;
        for (int unsigned i = 0; i < NUM_BYTES; i++) begin
            if (w_lane == CNT_W'(i)) begin
                w_asm_wr[i*UART_BYTE_W +: UART_BYTE_W] = BYTE_DATA;
            end
        end

        if (w_store) begin
            if (w_idx == CNT_W'(NUM_BYTES - 1)) begin
                w_frame_nxt  = w_asm_wr;
                w_fvalid_nxt = 1'b1;
                w_asm_nxt    = '0;
                w_count_nxt  = '0;
                w_state_nxt  = ST_HOLD;
            end else begin
                w_asm_nxt   = w_asm_wr;
                w_count_nxt = w_idx + CNT_W'(1);
                w_state_nxt = ST_COLLECT;
            end
        end
    end

    // Datapath and output registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_count  <= '0;
            r_asm    <= '0;
            r_frame  <= '0;
            r_fvalid <= 1'b0;
            r_ovf    <= 1'b0;
            r_tout   <= 1'b0;
        end else begin
            r_count  <= w_count_nxt;
            r_asm    <= w_asm_nxt;
            r_frame  <= w_frame_nxt;
            r_fvalid <= w_fvalid_nxt;
            r_ovf    <= w_ovf_nxt;
            r_tout   <= w_tout_nxt;
        end
    end

    assign FRAME_DATA  = r_frame;
    assign FRAME_VALID = r_fvalid;
    assign BYTE_COUNT  = r_count;
    assign OVERFLOW    = r_ovf;
    assign TIMEOUT_ERR = r_tout;

endmodule

// File: tb/tb_uart_frame_assembler.sv
// ---------------------------------------------------------------------------
// tb_uart_frame_assembler
//  Two assemblers (LSB-first and MSB-first, 8 bytes, 100-cycle timeout)
//  share one byte stream. Expected frames are queued when their bytes are
//  driven and compared when each instance transfers a frame.
// ---------------------------------------------------------------------------
module tb_uart_frame_assembler;

    logic        CLK = 1'b0;
    logic        RST;
    logic        BYTE_VALID;
    logic [7:0]  BYTE_DATA;
    logic        FRAME_READY;

    logic [63:0] fd_l, fd_m;
    logic        fv_l, fv_m;
    logic [3:0]  bc_l, bc_m;
    logic        ovf_l, ovf_m;
    logic        to_l, to_m;

    int          total = 0;
    int          bad   = 0;
    int          ovf_cnt_l = 0, ovf_cnt_m = 0;
    int          to_cnt_l  = 0, to_cnt_m  = 0;
    logic [63:0] q_l[$];
    logic [63:0] q_m[$];
    logic [7:0]  fb[8];

    logic        prev_v_l = 1'b0, prev_r_l = 1'b0;
    logic [63:0] prev_d_l = '0;

    always #5 CLK = ~CLK;

    uart_frame_assembler #(
        .NUM_BYTES      (8),
        .LSB_FIRST      (1'b1),
        .TIMEOUT_CYCLES (100)
    ) u_lsb (
        .CLK         (CLK),
        .RST         (RST),
        .BYTE_VALID  (BYTE_VALID),
        .BYTE_DATA   (BYTE_DATA),
        .FRAME_DATA  (fd_l),
        .FRAME_VALID (fv_l),
        .FRAME_READY (FRAME_READY),
        .BYTE_COUNT  (bc_l),
        .OVERFLOW    (ovf_l),
        .TIMEOUT_ERR (to_l)
    );

    uart_frame_assembler #(
        .NUM_BYTES      (8),
        .LSB_FIRST      (1'b0),
        .TIMEOUT_CYCLES (100)
    ) u_msb (
        .CLK         (CLK),
        .RST         (RST),
        .BYTE_VALID  (BYTE_VALID),
        .BYTE_DATA   (BYTE_DATA),
        .FRAME_DATA  (fd_m),
        .FRAME_VALID (fv_m),
        .FRAME_READY (FRAME_READY),
        .BYTE_COUNT  (bc_m),
        .OVERFLOW    (ovf_m),
        .TIMEOUT_ERR (to_m)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] pack(input bit lsb);
        logic [63:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            if (lsb) r[8*k +: 8]     = fb[k];
            else     r[8*(7-k) +: 8] = fb[k];
        end
        return r;
    endfunction

    task automatic push_exp();
        q_l.push_back(pack(1'b1));
        q_m.push_back(pack(1'b0));
    endtask

    task automatic fill(input logic [7:0] first);
        for (int k = 0; k < 8; k++) fb[k] = first + 8'(k);
    endtask

    // Inputs change 1 time unit after the rising edge; one byte per cycle.
    task automatic send_byte(input logic [7:0] b);
        BYTE_VALID = 1'b1;
        BYTE_DATA  = b;
        @(posedge CLK); #1;
        BYTE_VALID = 1'b0;
        BYTE_DATA  = 8'h00;
    endtask

    task automatic send_range(input int lo, input int hi);
        for (int k = lo; k <= hi; k++) send_byte(fb[k]);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK); #1;
        end
    endtask

    // Scoreboard: compare every transfer against the queued expectation.
    always @(negedge CLK) begin
        if (!RST) begin
            if (fv_l && FRAME_READY) begin
                if (q_l.size() == 0) chk("unexp_frame_l", 64'd1, 64'd0);
                else                 chk("frame_l", fd_l, q_l.pop_front());
            end
            if (fv_m && FRAME_READY) begin
                if (q_m.size() == 0) chk("unexp_frame_m", 64'd1, 64'd0);
                else                 chk("frame_m", fd_m, q_m.pop_front());
            end
            if (ovf_l) ovf_cnt_l++;
            if (ovf_m) ovf_cnt_m++;
            if (to_l)  to_cnt_l++;
            if (to_m)  to_cnt_m++;
            // A held frame may not drop or change without a transfer.
            if (prev_v_l && !prev_r_l) begin
                chk("hold_valid", 64'(fv_l), 64'd1);
                chk("hold_data", fd_l, prev_d_l);
            end
            prev_v_l <= fv_l;
            prev_r_l <= FRAME_READY;
            prev_d_l <= fd_l;
        end else begin
            prev_v_l <= 1'b0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        RST         = 1'b1;
        BYTE_VALID  = 1'b0;
        BYTE_DATA   = 8'h00;
        FRAME_READY = 1'b1;
        #1;
        chk("rst_fv", 64'(fv_l), 64'd0);
        chk("rst_bc", 64'(bc_l), 64'd0);
        chk("rst_fd", fd_l, 64'd0);
        chk("rst_ovf_to", 64'({ovf_l, to_l, ovf_m, to_m}), 64'd0);
        @(posedge CLK); @(posedge CLK); #1;
        RST = 1'b0;

        // Bytes 01..08 with READY high: one-cycle valid, both byte orders.
        fill(8'h01);
        push_exp();
        send_range(0, 7);
        chk("lat_fv_l", 64'(fv_l), 64'd1);
        chk("lat_fv_m", 64'(fv_m), 64'd1);
        chk("lsb_frame", fd_l, 64'h0807060504030201);
        chk("msb_frame", fd_m, 64'h0102030405060708);
        idle(1);
        chk("fv_drop", 64'(fv_l), 64'd0);
        chk("bc_idle", 64'(bc_l), 64'd0);

        // Overflow while holding a frame.
        FRAME_READY = 1'b0;
        fill(8'h11);
        push_exp();
        send_range(0, 7);
        chk("hold_fv", 64'(fv_l), 64'd1);
        idle(2);
        send_byte(8'hAA);
        chk("ovf_l", 64'(ovf_l), 64'd1);
        chk("ovf_m", 64'(ovf_m), 64'd1);
        chk("ovf_fd", fd_l, 64'h1817161514131211);
        idle(1);
        chk("ovf_pulse", 64'(ovf_l), 64'd0);
        FRAME_READY = 1'b1;
        idle(1);
        chk("ovf_after_fv", 64'(fv_l), 64'd0);
        chk("ovf_after_bc", 64'(bc_l), 64'd0);

        // Timeout after 3 bytes and 100 idle cycles.
        fill(8'h21);
        send_range(0, 2);
        chk("to_bc3", 64'(bc_l), 64'd3);
        idle(99);
        chk("to_early", 64'(to_l), 64'd0);
        chk("to_early_bc", 64'(bc_l), 64'd3);
        idle(1);
        chk("to_l", 64'(to_l), 64'd1);
        chk("to_m", 64'(to_m), 64'd1);
        chk("to_bc0", 64'(bc_l), 64'd0);
        idle(1);
        chk("to_pulse", 64'(to_l), 64'd0);
        fill(8'h31);
        push_exp();
        send_range(0, 7);
        idle(1);

        // A byte in the expiry cycle beats the timeout.
        fill(8'h41);
        push_exp();
        send_range(0, 1);
        idle(99);
        send_byte(fb[2]);
        chk("exp_win_to", 64'(to_l), 64'd0);
        chk("exp_win_bc", 64'(bc_l), 64'd3);
        send_range(3, 7);
        idle(1);

        // Transfer and first byte of the next frame in the same cycle.
        FRAME_READY = 1'b0;
        fill(8'h51);
        push_exp();
        send_range(0, 7);
        chk("b2b_hold", 64'(fv_l), 64'd1);
        fill(8'h60);
        fb[0] = 8'h5A;
        push_exp();
        FRAME_READY = 1'b1;
        send_byte(fb[0]);
        chk("b2b_bc", 64'(bc_l), 64'd1);
        chk("b2b_fv", 64'(fv_l), 64'd0);
        send_range(1, 7);
        idle(1);

        // Asynchronous reset mid-frame clears everything at once.
        fill(8'h71);
        send_range(0, 3);
        chk("pre_rst_bc", 64'(bc_l), 64'd4);
        RST = 1'b1;
        #1;
        chk("mid_rst_bc", 64'(bc_l), 64'd0);
        chk("mid_rst_fd", fd_l, 64'd0);
        chk("mid_rst_fv", 64'({fv_l, fv_m}), 64'd0);
        chk("mid_rst_pulses", 64'({ovf_l, to_l, ovf_m, to_m}), 64'd0);
        @(posedge CLK); #1;
        RST = 1'b0;
        fill(8'h81);
        push_exp();
        send_range(0, 7);
        idle(2);

        chk("q_l_empty", 64'(q_l.size()), 64'd0);
        chk("q_m_empty", 64'(q_m.size()), 64'd0);
        chk("ovf_cnt_l", 64'(ovf_cnt_l), 64'd1);
        chk("ovf_cnt_m", 64'(ovf_cnt_m), 64'd1);
        chk("to_cnt_l", 64'(to_cnt_l), 64'd1);
        chk("to_cnt_m", 64'(to_cnt_m), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
